// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 4-register in-order pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Tracks outstanding memory requests, muldiv occupancy of EX and deferred branch redirects.
module pipe_hazard_ctrl #(
  parameter int PC_W       = 64,
  parameter int LREG_W     = 5,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [LREG_W-1:0] id_rs1,
  input  logic [LREG_W-1:0] id_rs2,
  input  logic              id_src1_is_reg,
  input  logic              id_src2_is_reg,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [LREG_W-1:0] ex_rd,
  input  logic              ex_is_muldiv,
  input  logic              ex_redirect_valid,
  input  logic [PC_W-1:0]   ex_redirect_pc,
  input  logic              mem_valid,
  input  logic              mem_is_ls,
  input  logic              mem_resp_valid,
  output logic [3:0]        stall,
  output logic [3:0]        flush,
  output logic              fetch_stall,
  output logic              mem_req_valid,
  output logic              redirect_fire,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              md_busy
);

  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  localparam int CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_LAT - 2);

  mem_state_t       mem_state;
  md_state_t        md_state;
  logic [CNT_W-1:0] md_cnt;
  logic             redir_pend;
  logic [PC_W-1:0]  redirect_pc_q;

  logic mem_wait;
  logic md_wait;
  logic load_use;
  logic hold_ex;
  logic redir_req;

  assign mem_req_valid = mem_valid & mem_is_ls & (mem_state == MEM_IDLE);
  assign mem_wait      = mem_valid & mem_is_ls & ~mem_resp_valid;
  assign md_wait       = ex_valid & ex_is_muldiv & (md_state != MD_DONE);
  assign md_busy       = (md_state == MD_BUSY);

  assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != '0) &
                    ((id_src1_is_reg & (id_rs1 == ex_rd)) |
                     (id_src2_is_reg & (id_rs2 == ex_rd)));

  // EX is held exactly when either of the two higher-priority waits is active.
  assign hold_ex       = mem_wait | md_wait;
  assign redir_req     = ex_redirect_valid | redir_pend;
  assign redirect_fire = redir_req & ~hold_ex;
  assign redirect_pc   = redirect_fire ? (redir_pend ? redirect_pc_q : ex_redirect_pc) : '0;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    stall       = 4'b0000;
    flush       = 4'b0000;
    fetch_stall = 1'b0;
    if (mem_wait) begin
      stall       = 4'b0111;
      flush       = 4'b1000;
      fetch_stall = 1'b1;
    end else if (md_wait) begin
      stall       = 4'b0011;
      flush       = 4'b0100;
      fetch_stall = 1'b1;
    end else if (redirect_fire) begin
      flush       = 4'b0011;
    end else if (load_use) begin
      stall       = 4'b0001;
      flush       = 4'b0010;
      fetch_stall = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_state <= MEM_IDLE;
    end else begin
      case (mem_state)
        MEM_IDLE: if (mem_req_valid && !mem_resp_valid) mem_state <= MEM_WAIT;
        MEM_WAIT: if (mem_resp_valid) mem_state <= MEM_IDLE;
        default:  mem_state <= MEM_IDLE;
      endcase
    end
  end

  // BUSY lasts MULDIV_LAT-2 cycles, so with the IDLE cycle EX stalls MULDIV_LAT-1 cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (ex_valid && ex_is_muldiv) begin
            md_state <= (MULDIV_LAT > 2) ? MD_BUSY : MD_DONE;
            md_cnt   <= MD_LOAD;
          end
        end
        MD_BUSY: begin
          if (md_cnt <= CNT_W'(1)) begin
            md_state <= MD_DONE;
            md_cnt   <= '0;
          end else begin
            md_cnt <= md_cnt - CNT_W'(1);
          end
        end
        MD_DONE: if (!hold_ex) md_state <= MD_IDLE;
        default: md_state <= MD_IDLE;
      endcase
    end
  end

  // The first target seen while EX is held is kept until the redirect fires.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      redir_pend    <= 1'b0;
      redirect_pc_q <= '0;
    end else if (redirect_fire) begin
      redir_pend <= 1'b0;
    end else if (ex_redirect_valid && hold_ex && !redir_pend) begin
      redir_pend    <= 1'b1;
      redirect_pc_q <= ex_redirect_pc;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus a randomized run against
// a small pipeline-occupancy model of the IF/ID, ID/EX and EX/MEM registers.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;

  logic        clock;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_src1_is_reg;
  logic        id_src2_is_reg;
  logic        ex_valid;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        ex_is_muldiv;
  logic        ex_redirect_valid;
  logic [63:0] ex_redirect_pc;
  logic        mem_valid;
  logic        mem_is_ls;
  logic        mem_resp_valid;
  logic [3:0]  stall;
  logic [3:0]  flush;
  logic        fetch_stall;
  logic        mem_req_valid;
  logic        redirect_fire;
  logic [63:0] redirect_pc;
  logic        md_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // {stall, flush, fetch_stall, mem_req_valid, redirect_fire, md_busy}
  logic [11:0] ctl;
  assign ctl = {stall, flush, fetch_stall, mem_req_valid, redirect_fire, md_busy};

  pipe_hazard_ctrl #(.PC_W(64), .LREG_W(5), .MULDIV_LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_src1_is_reg(id_src1_is_reg), .id_src2_is_reg(id_src2_is_reg),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_is_muldiv(ex_is_muldiv), .ex_redirect_valid(ex_redirect_valid),
    .ex_redirect_pc(ex_redirect_pc), .mem_valid(mem_valid), .mem_is_ls(mem_is_ls),
    .mem_resp_valid(mem_resp_valid), .stall(stall), .flush(flush),
    .fetch_stall(fetch_stall), .mem_req_valid(mem_req_valid),
    .redirect_fire(redirect_fire), .redirect_pc(redirect_pc), .md_busy(md_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  typedef struct packed {
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        s1;
    logic        s2;
    logic        load;
    logic        muldiv;
    logic        ls;
    logic        br;
    logic [4:0]  rd;
    logic [63:0] pc;
  } instr_t;

  task automatic clear_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_src1_is_reg = 0; id_src2_is_reg = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_is_muldiv = 0;
    ex_redirect_valid = 0; ex_redirect_pc = 0;
    mem_valid = 0; mem_is_ls = 0; mem_resp_valid = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #3;
    n_tests++;
    if ({ctl, redirect_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ctl=%b pc=%h want all zero", ctl, redirect_pc);
    end
    tick();
    tick();
    reset_n = 1'b1;
    #2;
    n_tests++;
    if ({ctl, redirect_pc} !== '0) begin
      n_fail++;
      $display("FAIL after_reset got ctl=%b pc=%h want all zero", ctl, redirect_pc);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [11:0] exp;
    clear_inputs();
    ex_valid = 1; ex_is_load = 1; ex_rd = 5;
    id_valid = 1; id_rs1 = 5; id_src1_is_reg = 1;
    #2;
    exp = 12'b0001_0010_1_0_0_0;
    n_tests++;
    if (ctl !== exp) begin n_fail++; $display("FAIL lu_rs1 got %b want %b", ctl, exp); end
    tick();
    ex_valid = 0; ex_is_load = 0;
    #2;
    n_tests++;
    if (ctl !== 12'd0) begin n_fail++; $display("FAIL lu_next got %b want 0", ctl); end
    tick();
    ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_rs1 = 0;
    #2;
    n_tests++;
    if (ctl !== 12'd0) begin n_fail++; $display("FAIL lu_rd0 got %b want 0", ctl); end
    tick();
    ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_src2_is_reg = 1;
    #2;
    n_tests++;
    if (ctl !== exp) begin n_fail++; $display("FAIL lu_rs2 got %b want %b", ctl, exp); end
    tick();
    id_src2_is_reg = 0;
    #2;
    n_tests++;
    if (ctl !== 12'd0) begin n_fail++; $display("FAIL lu_rs2_imm got %b want 0", ctl); end
    tick();
  endtask

  task automatic test_muldiv();
    logic [11:0] exp;
    clear_inputs();
    ex_valid = 1; ex_is_muldiv = 1;
    for (int c = 0; c < LAT; c++) begin
      #2;
      if (c < LAT - 1) exp = {4'b0011, 4'b0100, 1'b1, 1'b0, 1'b0, (c >= 1 && c <= LAT - 2)};
      else             exp = 12'd0;
      n_tests++;
      if (ctl !== exp) begin n_fail++; $display("FAIL muldiv_c%0d got %b want %b", c, ctl, exp); end
      tick();
    end
    clear_inputs();
    #2;
    n_tests++;
    if (ctl !== 12'd0) begin n_fail++; $display("FAIL muldiv_after got %b want 0", ctl); end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [11:0] exp;
    clear_inputs();
    mem_valid = 1; mem_is_ls = 1;
    for (int c = 0; c < 4; c++) begin
      mem_resp_valid = (c == 3);
      #2;
      if (c < 3) exp = {4'b0111, 4'b1000, 1'b1, (c == 0), 1'b0, 1'b0};
      else       exp = 12'd0;
      n_tests++;
      if (ctl !== exp) begin n_fail++; $display("FAIL memwait_c%0d got %b want %b", c, ctl, exp); end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      mem_resp_valid = 1;
      #2;
      exp = 12'b0000_0000_0_1_0_0;
      n_tests++;
      if (ctl !== exp) begin n_fail++; $display("FAIL mem_zero_lat%0d got %b want %b", c, ctl, exp); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_redirect_mem();
    logic [11:0] exp;
    clear_inputs();
    mem_valid = 1; mem_is_ls = 1;
    ex_valid = 1; ex_redirect_valid = 1; ex_redirect_pc = 64'h8000_0100;
    for (int c = 0; c < 2; c++) begin
      #2;
      exp = {4'b0111, 4'b1000, 1'b1, (c == 0), 1'b0, 1'b0};
      n_tests++;
      if (ctl !== exp) begin n_fail++; $display("FAIL redir_wait%0d got %b want %b", c, ctl, exp); end
      tick();
    end
    // Release cycle: only the latched target can supply the PC.
    mem_resp_valid = 1; ex_redirect_valid = 0; ex_redirect_pc = 64'h0;
    #2;
    exp = 12'b0000_0011_0_0_1_0;
    n_tests++;
    if (ctl !== exp) begin n_fail++; $display("FAIL redir_release got %b want %b", ctl, exp); end
    n_tests++;
    if (redirect_pc !== 64'h8000_0100) begin
      n_fail++;
      $display("FAIL redir_pc got %h want %h", redirect_pc, 64'h8000_0100);
    end
    tick();
    clear_inputs();
    #2;
    n_tests++;
    if (redirect_fire !== 1'b0) begin n_fail++; $display("FAIL redir_once got %b want 0", redirect_fire); end
    tick();
  endtask

  task automatic test_redirect_lu();
    logic [11:0] exp;
    clear_inputs();
    ex_valid = 1; ex_is_load = 1; ex_rd = 3;
    id_valid = 1; id_rs2 = 3; id_src2_is_reg = 1;
    ex_redirect_valid = 1; ex_redirect_pc = 64'h0000_0000_0000_1234;
    #2;
    exp = 12'b0000_0011_0_0_1_0;
    n_tests++;
    if (ctl !== exp) begin n_fail++; $display("FAIL redir_lu got %b want %b", ctl, exp); end
    n_tests++;
    if (redirect_pc !== 64'h1234) begin
      n_fail++;
      $display("FAIL redir_lu_pc got %h want %h", redirect_pc, 64'h1234);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    clear_inputs();
    ex_valid = 1; ex_is_muldiv = 1; ex_redirect_valid = 1; ex_redirect_pc = 64'hdead_beef_0000_0040;
    tick();
    #2;
    exp = 12'b0011_0100_1_0_0_1;
    n_tests++;
    if (ctl !== exp) begin n_fail++; $display("FAIL rstmid_busy got %b want %b", ctl, exp); end
    clear_inputs();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({ctl, redirect_pc} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async got ctl=%b pc=%h want all zero", ctl, redirect_pc);
    end
    tick();
    reset_n = 1'b1;
    #2;
    n_tests++;
    if ({md_busy, redirect_fire} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_release got md_busy=%b fire=%b want 0 0", md_busy, redirect_fire);
    end
    tick();
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i        = '0;
    i.v      = 1'b1;
    i.rs1    = 5'($urandom_range(0, 7));
    i.rs2    = 5'($urandom_range(0, 7));
    i.s1     = 1'($urandom_range(0, 1));
    i.s2     = 1'($urandom_range(0, 1));
    i.rd     = 5'($urandom_range(0, 7));
    i.load   = ($urandom_range(0, 3) == 0);
    i.muldiv = !i.load && ($urandom_range(0, 9) == 0);
    i.br     = !i.load && !i.muldiv && ($urandom_range(0, 7) == 0);
    i.ls     = i.load || ($urandom_range(0, 6) == 0);
    i.pc     = {$urandom, $urandom};
    return i;
  endfunction

  // Model: an instruction occupies EX for at least LAT cycles-minus-one if it is a muldiv,
  // MEM waits until a response arrives, and a redirect leaves EX on its first unheld cycle.
  task automatic test_random(input int cycles);
    instr_t id_i, ex_i, mem_i;
    int          ex_age;
    bit          req_sent, pend, e_mw, e_md, e_lu, e_fire, e_mreq, e_busy, e_fs;
    logic [63:0] pend_pc, e_pc;
    logic [3:0]  e_st, e_fl;
    logic [11:0] exp;
    clear_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    id_i = '0; ex_i = '0; mem_i = '0;
    ex_age = 0; req_sent = 0; pend = 0; pend_pc = '0;
    for (int c = 0; c < cycles; c++) begin
      id_valid = id_i.v; id_rs1 = id_i.rs1; id_rs2 = id_i.rs2;
      id_src1_is_reg = id_i.s1; id_src2_is_reg = id_i.s2;
      ex_valid = ex_i.v; ex_is_load = ex_i.load; ex_rd = ex_i.rd; ex_is_muldiv = ex_i.muldiv;
      ex_redirect_valid = ex_i.v & ex_i.br; ex_redirect_pc = ex_i.pc;
      mem_valid = mem_i.v; mem_is_ls = mem_i.ls;
      mem_resp_valid = mem_i.v & mem_i.ls & ($urandom_range(0, 2) == 0);

      e_mw   = mem_i.v && mem_i.ls && !mem_resp_valid;
      e_md   = ex_i.v && ex_i.muldiv && (ex_age < LAT - 1);
      e_busy = ex_i.v && ex_i.muldiv && (ex_age >= 1) && (ex_age <= LAT - 2);
      e_lu   = id_i.v && ex_i.v && ex_i.load && (ex_i.rd != 0) &&
               ((id_i.s1 && id_i.rs1 == ex_i.rd) || (id_i.s2 && id_i.rs2 == ex_i.rd));
      e_fire = ((ex_i.v && ex_i.br) || pend) && !e_mw && !e_md;
      e_pc   = e_fire ? (pend ? pend_pc : ex_i.pc) : 64'h0;
      e_mreq = mem_i.v && mem_i.ls && !req_sent;
      if (e_mw)        begin e_st = 4'b0111; e_fl = 4'b1000; e_fs = 1; end
      else if (e_md)   begin e_st = 4'b0011; e_fl = 4'b0100; e_fs = 1; end
      else if (e_fire) begin e_st = 4'b0000; e_fl = 4'b0011; e_fs = 0; end
      else if (e_lu)   begin e_st = 4'b0001; e_fl = 4'b0010; e_fs = 1; end
      else             begin e_st = 4'b0000; e_fl = 4'b0000; e_fs = 0; end
      exp = {e_st, e_fl, e_fs, e_mreq, e_fire, e_busy};

      #2;
      n_tests++;
      if (ctl !== exp) begin n_fail++; $display("FAIL rnd_ctl cyc=%0d got %b want %b", c, ctl, exp); end
      n_tests++;
      if (redirect_pc !== e_pc) begin
        n_fail++;
        $display("FAIL rnd_pc cyc=%0d got %h want %h", c, redirect_pc, e_pc);
      end
      tick();

      if (e_fire) pend = 0;
      else if (ex_i.v && ex_i.br && e_st[1] && !pend) begin pend = 1; pend_pc = ex_i.pc; end
      req_sent = e_st[2] ? (req_sent | e_mreq) : 1'b0;
      ex_age   = e_st[1] ? ex_age + 1 : 0;
      if (!e_st[2]) mem_i = e_fl[2] ? '0 : ex_i;
      if (!e_st[1]) ex_i  = e_fl[1] ? '0 : id_i;
      if (!e_st[0]) id_i  = e_fl[0] ? '0 : rand_instr();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_load_use();
    test_muldiv();
    test_mem_wait();
    test_redirect_mem();
    test_redirect_lu();
    test_reset_mid();
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 4-register in-order pipeline built from pipereg instances: reg0=IF/ID, reg1=ID/EX, reg2=EX/MEM, reg3=MEM/WB.
- Detects load-use hazards, sequences multi-cycle muldiv occupancy of EX, and waits on memory responses in MEM.
- Defers and applies EX-stage branch redirects.
- Drives each pipereg's stall and redirect_flush inputs and the fetch stall.

Parameters:
PC_W, 64, redirect PC width
LREG_W, 5, logical register index width
MULDIV_LAT, 4, EX occupancy cycles of a muldiv op (>=2)

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  reg0 output valid (instr in ID)
id_rs1  in  LREG_W  ID source 1
id_rs2  in  LREG_W  ID source 2
id_src1_is_reg  in  1  rs1 read from regfile
id_src2_is_reg  in  1  rs2 read from regfile
ex_valid  in  1  reg1 output valid (instr in EX)
ex_is_load  in  1  EX instr is load
ex_rd  in  LREG_W  EX destination
ex_is_muldiv  in  1  EX instr is muldiv
ex_redirect_valid  in  1  EX branch mispredict/jump
ex_redirect_pc  in  PC_W  redirect target
mem_valid  in  1  reg2 output valid
mem_is_ls  in  1  MEM instr is load or store
mem_resp_valid  in  1  memory response this cycle
stall  out  4  per-reg stall, bit k -> reg k
flush  out  4  per-reg redirect_flush, bit k -> reg k
fetch_stall  out  1  hold fetch PC
mem_req_valid  out  1  issue memory request
redirect_fire  out  1  one-cycle redirect to fetch
redirect_pc  out  PC_W  target, valid with redirect_fire
md_busy  out  1  muldiv counting

Behaviour:
- Pipereg semantics: flush[k] clears reg k only when stall[k]=0; stall[k] holds reg k. "Bubble into k" means stall[k]=0 and flush[k]=1.
- All outputs are combinational from the registered state and the inputs.
- Reset: mem FSM=IDLE, md FSM=IDLE, md count=0, redir_pend=0, redirect_pc_q=0. With all inputs 0, every output is 0.

Mem FSM (IDLE, WAIT):
- mem_req_valid = mem_valid & mem_is_ls & state==IDLE.
- IDLE -> WAIT on a request with no same-cycle mem_resp_valid.
- WAIT -> IDLE on mem_resp_valid.
- mem_wait = mem_valid & mem_is_ls & ~mem_resp_valid.
- A zero-latency response (request and response in the same cycle) gives no wait.

Muldiv FSM (IDLE, BUSY, DONE):
- IDLE -> BUSY when ex_valid & ex_is_muldiv; count loads MULDIV_LAT-2.
- BUSY: count decrements; at count==0 go to DONE.
- DONE -> IDLE when the EX instr advances (stall[1]=0).
- md_wait = ex_valid & ex_is_muldiv & state!=DONE. EX therefore stalls exactly MULDIV_LAT-1 cycles.
- Counting continues during mem_wait.
- md_busy = (state==BUSY).

Load-use:
- lu = id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_src1_is_reg & id_rs1==ex_rd) | (id_src2_is_reg & id_rs2==ex_rd)).

Redirect:
- req = ex_redirect_valid | redir_pend.
- On ex_redirect_valid & stall[1], set redir_pend and latch the PC. Repeated assertion while pending is idempotent.
- Fire when req & stall[1]=0:
  - redirect_fire=1; redirect_pc = latched PC if pending, else ex_redirect_pc.
  - Bubble into reg0 and reg1.
  - Clear redir_pend.

Priority (highest first); stall bits are OR-accumulated:
1. mem_wait: stall[2:0]=1, bubble into reg3, fetch_stall=1.
2. md_wait: stall[1:0]=1, bubble into reg2, fetch_stall=1.
3. redirect fire: as above; overrides lu. fetch_stall=0.
4. lu: stall[0]=1, bubble into reg1, fetch_stall=1.
5. Otherwise all stall=0, flush=0.

Boundary conditions:
- Reset mid-operation aborts both FSMs and the pending redirect immediately.
- A mem response arriving in WAIT releases the stall in that same cycle.

Test Plan:
- Load-use: EX load x5, ID add rs1=x5 -> 1 cycle of stall[0]=1, flush[1]=1, fetch_stall=1. Next cycle no stall. ex_rd=0 -> no stall.
- Muldiv, MULDIV_LAT=4: EX mul at cycle 0 -> stall[1:0]=2'b11, flush[2]=1 for cycles 0-2; cycle 3 stall=0; md_busy high cycles 1-2.
- Mem wait: load in MEM, resp 3 cycles after request -> mem_req_valid only in cycle 0; stall[2:0]=3'b111, flush[3]=1 for 3 cycles; same-cycle resp -> zero stalls.
- Redirect during mem wait: ex_redirect_valid, pc=0x8000_0100, while mem_wait for 2 cycles -> redirect_fire=0 during the wait. On the release cycle: redirect_fire=1, redirect_pc=0x8000_0100, flush[1:0]=2'b11, fired exactly once.
- Redirect + load-use in the same cycle -> redirect wins: flush[1:0]=2'b11, stall[0]=0.
- reset_n low during muldiv BUSY and pending redirect -> all outputs 0 asynchronously; after release, md_busy=0 and redirect_fire=0.
